// File: rtl/scr1_mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single memory port. Round-robin on ties,
// at most one outstanding transaction, back-to-back handshakes on RDY_OK.
package scr1_memif_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_mem_arbiter
    import scr1_memif_pkg::*;
#(
    parameter int SCR1_ARB_AWIDTH = 32,
    parameter int SCR1_ARB_DWIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    // port 0: instruction fetch
    input  logic                       imem_req,
    output logic                       imem_req_ack,
    input  logic [SCR1_ARB_AWIDTH-1:0] imem_addr,
    output logic [SCR1_ARB_DWIDTH-1:0] imem_rdata,
    output type_scr1_mem_resp_e        imem_resp,
    // port 1: data
    input  logic                       dmem_req,
    output logic                       dmem_req_ack,
    input  type_scr1_mem_cmd_e         dmem_cmd,
    input  type_scr1_mem_width_e       dmem_width,
    input  logic [SCR1_ARB_AWIDTH-1:0] dmem_addr,
    input  logic [SCR1_ARB_DWIDTH-1:0] dmem_wdata,
    output logic [SCR1_ARB_DWIDTH-1:0] dmem_rdata,
    output type_scr1_mem_resp_e        dmem_resp,
    // shared memory port
    output logic                       mem_req,
    input  logic                       mem_req_ack,
    output type_scr1_mem_cmd_e         mem_cmd,
    output type_scr1_mem_width_e       mem_width,
    output logic [SCR1_ARB_AWIDTH-1:0] mem_addr,
    output logic [SCR1_ARB_DWIDTH-1:0] mem_wdata,
    input  logic [SCR1_ARB_DWIDTH-1:0] mem_rdata,
    input  type_scr1_mem_resp_e        mem_resp
);

    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_DATA  = 1'b1;
    localparam logic       PORT_IMEM = 1'b0;
    localparam logic       PORT_DMEM = 1'b1;

    logic [0:0] fsm;
    logic       owner;
    logic       last_gnt;
    logic       arb_open;
    logic       grant;
    logic       handshake;

    // The window reopens in the same cycle the current owner gets RDY_OK, giving
    // zero-bubble back-to-back transfers; RDY_ER keeps it closed for that cycle.
    assign arb_open = ~rst & ((fsm == ARB_IDLE) | (mem_resp == SCR1_MEM_RESP_RDY_OK));

    always_comb begin
        grant = PORT_IMEM;
        if (imem_req & dmem_req) grant = ~last_gnt;
        else if (dmem_req)       grant = PORT_DMEM;
    end

    assign mem_req   = arb_open & (imem_req | dmem_req);
    assign handshake = mem_req & mem_req_ack;

    assign imem_req_ack = mem_req & mem_req_ack & (grant == PORT_IMEM);
    assign dmem_req_ack = mem_req & mem_req_ack & (grant == PORT_DMEM);

    always_comb begin
        mem_cmd   = SCR1_MEM_CMD_RD;
        mem_width = SCR1_MEM_WIDTH_WORD;
        mem_addr  = imem_addr;
        mem_wdata = '0;
        if (grant == PORT_DMEM) begin
            mem_cmd   = dmem_cmd;
            mem_width = dmem_width;
            mem_addr  = dmem_addr;
            mem_wdata = dmem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm      <= ARB_IDLE;
            owner    <= PORT_IMEM;
            last_gnt <= PORT_DMEM;
        end else if (handshake) begin
            fsm      <= ARB_DATA;
            owner    <= grant;
            last_gnt <= grant;
        end else if ((fsm == ARB_DATA) &&
                     ((mem_resp == SCR1_MEM_RESP_RDY_OK) || (mem_resp == SCR1_MEM_RESP_RDY_ER))) begin
            fsm <= ARB_IDLE;
        end
    end

    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

    always_comb begin
        imem_resp = SCR1_MEM_RESP_NOTRDY;
        dmem_resp = SCR1_MEM_RESP_NOTRDY;
        if (~rst && (fsm == ARB_DATA)) begin
            if (owner == PORT_IMEM) imem_resp = mem_resp;
            else                    dmem_resp = mem_resp;
        end
    end

endmodule
